// File: rtl/user_obi_demux.sv
// ----------------------------------------------------------------------------
// user_obi_demux
//
// Routes one OBI manager port to NumRules subordinates plus an internal error
// subordinate. The address decode picks the lowest-indexed matching rule
// (start inclusive, end exclusive). An unmatched address goes to the internal
// error subordinate. That subordinate grants in the same cycle and answers one
// cycle later with err=1 and rdata=ErrData.
//
// Responses come back in request order. A new request whose target differs
// from the target of in-flight requests is stalled until every in-flight
// request has completed. Requests are also stalled when MaxOutstanding
// requests are already in flight.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mgr_req_i/gnt_o       manager request / grant
//   mgr_addr_i/we_i/be_i/wdata_i   manager request fields
//   mgr_rvalid_o/rdata_o/err_o     manager response (combinational from the
//                                  active subordinate, zero added latency)
//   sbr_req_o/gnt_i       per-subordinate request / grant
//   sbr_addr_o/we_o/be_o/wdata_o   request fields broadcast to all subordinates
//   sbr_rvalid_i/rdata_i/err_i     per-subordinate response; subordinate k's
//                                  rdata is at [32k+31:32k]
//   err_cnt_o             (only with USER_OBI_DEMUX_ERRCNT_EN) saturating count
//                         of error-subordinate handshakes plus forwarded
//                         responses that carry err=1
//
// Optional feature macro: USER_OBI_DEMUX_ERRCNT_EN
// ----------------------------------------------------------------------------
module user_obi_demux #(
    parameter int unsigned                NumRules       = 4,
    parameter logic [NumRules-1:0][31:0]  RuleStart      = {32'h2002_1000, 32'h2002_0000,
                                                            32'h2001_0000, 32'h2000_0000},
    parameter logic [NumRules-1:0][31:0]  RuleEnd        = {32'h2002_2000, 32'h2002_1000,
                                                            32'h2002_0000, 32'h2001_0000},
    parameter int unsigned                MaxOutstanding = 4,
    parameter logic [31:0]                ErrData        = 32'hBADC_AB1E
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     mgr_req_i,
    output logic                     mgr_gnt_o,
    input  logic [31:0]              mgr_addr_i,
    input  logic                     mgr_we_i,
    input  logic [3:0]               mgr_be_i,
    input  logic [31:0]              mgr_wdata_i,
    output logic                     mgr_rvalid_o,
    output logic [31:0]              mgr_rdata_o,
    output logic                     mgr_err_o,
    output logic [NumRules-1:0]      sbr_req_o,
    input  logic [NumRules-1:0]      sbr_gnt_i,
    output logic [31:0]              sbr_addr_o,
    output logic                     sbr_we_o,
    output logic [3:0]               sbr_be_o,
    output logic [31:0]              sbr_wdata_o,
    input  logic [NumRules-1:0]      sbr_rvalid_i,
    input  logic [NumRules*32-1:0]   sbr_rdata_i,
    input  logic [NumRules-1:0]      sbr_err_i
`ifdef USER_OBI_DEMUX_ERRCNT_EN
    ,
    output logic [15:0]              err_cnt_o
`endif
);

    // Target index encoding: 0..NumRules-1 are real subordinates, NumRules is
    // the internal error subordinate.
    localparam int unsigned     SelW   = $clog2(NumRules + 1);
    localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [SelW-1:0] SelErr = SelW'(NumRules);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CntOne = CntW'(32'd1);
    localparam logic [CntW-1:0] CntZero = CntW'(32'd0);

    logic [SelW-1:0] sel_s;
    logic            hit_s;
    logic            tgt_gnt_s;
    logic            issue_ok_s;
    logic            hs_s;
    logic            rsp_vld_raw_s;
    logic [31:0]     rsp_data_s;
    logic            rsp_err_raw_s;
    logic            rsp_real_s;

    logic [CntW-1:0] out_cnt_r;
    logic [SelW-1:0] last_sel_r;
    logic            err_pend_r;

    // Request fields go to every subordinate unchanged; only req is steered.
    assign sbr_addr_o  = mgr_addr_i;
    assign sbr_we_o    = mgr_we_i;
    assign sbr_be_o    = mgr_be_i;
    assign sbr_wdata_o = mgr_wdata_i;

    // Address decode: the first matching rule in ascending index order wins.
    always_comb begin
        sel_s = SelErr;
        hit_s = 1'b0;
        for (int k = 0; k < int'(NumRules); k++) begin
            if (!hit_s && (mgr_addr_i >= RuleStart[k]) && (mgr_addr_i < RuleEnd[k])) begin
                hit_s = 1'b1;
                sel_s = SelW'(k);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // AND-OR muxes: grant of the decoded target, response of the active target.
    // When the active target is the error subordinate, no real index matches
    // and the response fields stay zero.
    always_comb begin
        tgt_gnt_s     = 1'b0;
        rsp_vld_raw_s = 1'b0;
        rsp_data_s    = 32'h0000_0000;
        rsp_err_raw_s = 1'b0;
        for (int k = 0; k < int'(NumRules); k++) begin
            tgt_gnt_s     = tgt_gnt_s | (sbr_gnt_i[k] & (sel_s == SelW'(k)));
            rsp_vld_raw_s = rsp_vld_raw_s | (sbr_rvalid_i[k] & (last_sel_r == SelW'(k)));
            rsp_err_raw_s = rsp_err_raw_s | (sbr_err_i[k] & (last_sel_r == SelW'(k)));
            rsp_data_s    = rsp_data_s | (sbr_rdata_i[32*k +: 32] & {32{last_sel_r == SelW'(k)}});
        end
    end

    // Issue gating: a request may go out when nothing is in flight, or when it
    // targets the same subordinate as the in-flight requests and there is room.
    always_comb begin
        issue_ok_s = (out_cnt_r == CntZero) ||
                     ((sel_s == last_sel_r) && (out_cnt_r < CntMax));
        sbr_req_o  = {NumRules{1'b0}};
        if (issue_ok_s && (sel_s != SelErr)) begin
            mgr_gnt_o = tgt_gnt_s;
            for (int k = 0; k < int'(NumRules); k++) begin
                sbr_req_o[k] = mgr_req_i & (sel_s == SelW'(k));
            end
        end else if (issue_ok_s) begin
            mgr_gnt_o = mgr_req_i;
        end else begin
            mgr_gnt_o = 1'b0;
        end
    end

    assign hs_s = mgr_req_i & mgr_gnt_o;

    // A real response is accepted only from the active target, and only while
    // something is in flight. Stray or post-reset rvalids are dropped here.
    assign rsp_real_s = rsp_vld_raw_s & (last_sel_r != SelErr) & (out_cnt_r != CntZero);

    // Response mux: the error-subordinate answer takes precedence. It cannot
    // coincide with a real answer, because the target never switches while
    // requests are in flight.
    always_comb begin
        if (err_pend_r) begin
            mgr_rvalid_o = 1'b1;
            mgr_rdata_o  = ErrData;
            mgr_err_o    = 1'b1;
        end else if (rsp_real_s) begin
            mgr_rvalid_o = 1'b1;
            mgr_rdata_o  = rsp_data_s;
            mgr_err_o    = rsp_err_raw_s;
        end else begin
            mgr_rvalid_o = 1'b0;
            mgr_rdata_o  = 32'h0000_0000;
            mgr_err_o    = 1'b0;
        end
    end

    // Outstanding tracking: active target, in-flight count, pending error reply.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_cnt_r  <= CntZero;
            last_sel_r <= SelErr;
            err_pend_r <= 1'b0;
        end else begin
            err_pend_r <= hs_s & (sel_s == SelErr);
            if (hs_s) begin
                last_sel_r <= sel_s;
            end else begin
                last_sel_r <= last_sel_r;
            end
            case ({hs_s, mgr_rvalid_o})
                2'b10:   out_cnt_r <= out_cnt_r + CntOne;
                2'b01:   out_cnt_r <= out_cnt_r - CntOne;
                default: out_cnt_r <= out_cnt_r;
            endcase
        end
    end

`ifdef USER_OBI_DEMUX_ERRCNT_EN
    logic [15:0] err_cnt_r;
    logic [1:0]  err_inc_s;
    logic [16:0] err_sum_s;

    // Error events this cycle: an error-subordinate handshake and/or a
    // forwarded response flagged with err. Both together add 2.
    always_comb begin
        err_inc_s = {1'b0, hs_s & (sel_s == SelErr)} + {1'b0, rsp_real_s & rsp_err_raw_s};
        err_sum_s = {1'b0, err_cnt_r} + {15'h0000, err_inc_s};
    end

    // Saturating error counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_r <= 16'h0000;
        end else if (err_sum_s[16]) begin
            err_cnt_r <= 16'hFFFF;
        end else begin
            err_cnt_r <= err_sum_s[15:0];
        end
    end

    assign err_cnt_o = err_cnt_r;
`endif

endmodule
